// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: RGB332 colours, active-area geometry, pattern sizes.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

   // RGB332 colours: [7:5] R, [4:2] G, [1:0] B
   localparam logic [7:0] WHITE   = 8'hFF;
   localparam logic [7:0] YELLOW  = 8'hFC;
   localparam logic [7:0] CYAN    = 8'h1F;
   localparam logic [7:0] GREEN   = 8'h1C;
   localparam logic [7:0] MAGENTA = 8'hE3;
   localparam logic [7:0] RED     = 8'hE0;
   localparam logic [7:0] BLUE    = 8'h03;
   localparam logic [7:0] BLACK   = 8'h00;

   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int BAR_W     = 80;
   localparam int CELL_LOG2 = 5;
   localparam int MBAR_W    = 32;
   localparam int MBAR_STEP = 4;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_GRID  = 2'd2,
      MODE_MBAR  = 2'd3
   } mode_t;

   // Colour of each of the 8 vertical bars, left to right
   function automatic logic [7:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return WHITE;
         3'd1:    return YELLOW;
         3'd2:    return CYAN;
         3'd3:    return GREEN;
         3'd4:    return MAGENTA;
         3'd5:    return RED;
         3'd6:    return BLUE;
         default: return BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_bar_decode.sv
// Maps a pixel column to one of 8 colour-bar indices using comparisons against multiples of BAR_W.
// Latency: combinational.  Backpressure: none.
// Ports: x (pixel column, 10b) -> idx (bar index 0..7, 3b).
module vga_bar_decode
   import vga_pkg::*;
(
   input  logic [9:0] x,
   output logic [2:0] idx
);

   // Highest bar whose left edge is at or left of x wins; no divider needed.
   always_comb begin
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= 10'(i * BAR_W))
            idx = 3'(i);
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator behind a VGA timing stage: colour bars, checkerboard, grid, moving bar.
// Latency: fixed 2 cycles from HS/VS/x/y/blank to HS_O/VS_O/RGB.  Backpressure: none, one pixel per clock.
// Ports: CLK, RST (sync, active-high), HS/VS (active-low syncs), x, y, blank, MODE in; HS_O, VS_O, RGB (RGB332), FRAME out.
module vga_pattern_gen
   import vga_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       HS,
   input  logic       VS,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       blank,
   input  logic [1:0] MODE,
   output logic       HS_O,
   output logic       VS_O,
   output logic [7:0] RGB,
   output logic [7:0] FRAME
);

   // stage 1
   logic       hs1, vs1, blank1;
   logic [9:0] x1, y1;
   mode_t      mode1;
   // live1/live2: stage holds a real post-reset sample, so a fall across reset release is ignored
   logic       live1, live2;

   // per-frame state
   mode_t      active_mode;
   logic [9:0] bar_pos;

   logic       frame_start;
   logic [9:0] next_bar;
   logic [2:0] bar_idx;
   logic       in_mbar, on_grid;
   logic [7:0] pattern;

   // VS_O is the stage-2 copy of vs1, so this is a 1->0 edge on the stage-1 VS
   assign frame_start = live2 & VS_O & ~vs1;

   always_comb begin
      next_bar = bar_pos + 10'(MBAR_STEP);
      if ({1'b0, bar_pos} + 11'(MBAR_STEP) > 11'(H_ACTIVE - MBAR_STEP))
         next_bar = '0;
   end

   vga_bar_decode u_bar_decode (
      .x   (x1),
      .idx (bar_idx)
   );

   // 11-bit compare so bar_pos+MBAR_W never wraps back onto the left edge
   assign in_mbar = ({1'b0, x1} >= {1'b0, bar_pos}) &&
                    ({1'b0, x1} <  ({1'b0, bar_pos} + 11'(MBAR_W)));

   assign on_grid = (x1[CELL_LOG2-1:0] == '0) || (y1[CELL_LOG2-1:0] == '0) ||
                    (x1 == 10'(H_ACTIVE - 1)) || (y1 == 10'(V_ACTIVE - 1));

   // Uses the pre-update mode/bar_pos, so the pixel on the frame-start cycle keeps the old frame's look
   always_comb begin
      pattern = BLACK;
      case (active_mode)
         MODE_BARS:  pattern = bar_colour(bar_idx);
         MODE_CHECK: pattern = (x1[CELL_LOG2] ^ y1[CELL_LOG2]) ? WHITE : BLACK;
         MODE_GRID:  pattern = on_grid ? WHITE : BLUE;
         MODE_MBAR:  pattern = in_mbar ? WHITE : BLACK;
         default:    pattern = BLACK;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hs1         <= 1'b1;
         vs1         <= 1'b1;
         blank1      <= 1'b1;
         x1          <= '0;
         y1          <= '0;
         mode1       <= MODE_BARS;
         live1       <= 1'b0;
         live2       <= 1'b0;
         HS_O        <= 1'b1;
         VS_O        <= 1'b1;
         RGB         <= BLACK;
         FRAME       <= '0;
         active_mode <= MODE_BARS;
         bar_pos     <= '0;
      end else begin
         hs1    <= HS;
         vs1    <= VS;
         blank1 <= blank;
         x1     <= x;
         y1     <= y;
         mode1  <= mode_t'(MODE);
         live1  <= 1'b1;
         live2  <= live1;

         HS_O <= hs1;
         VS_O <= vs1;
         RGB  <= blank1 ? BLACK : pattern;

         if (frame_start) begin
            active_mode <= mode1;
            bar_pos     <= next_bar;
            FRAME       <= FRAME + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: stimulus pushes expected outputs, a monitor pops and compares.
// Latency: expected values are due 2 clocks after the sampling edge.
// Backpressure: none; the DUT produces one output per clock.
module tb_vga_pattern_gen;

   logic       CLK = 1'b0;
   logic       RST, HS, VS, blank;
   logic [9:0] x, y;
   logic [1:0] MODE;
   logic       HS_O, VS_O;
   logic [7:0] RGB, FRAME;

   always #5 CLK = ~CLK;

   vga_pattern_gen dut (
      .CLK   (CLK),
      .RST   (RST),
      .HS    (HS),
      .VS    (VS),
      .x     (x),
      .y     (y),
      .blank (blank),
      .MODE  (MODE),
      .HS_O  (HS_O),
      .VS_O  (VS_O),
      .RGB   (RGB),
      .FRAME (FRAME)
   );

   typedef struct {
      int         due;
      logic       hs;
      logic       vs;
      logic [7:0] rgb;
      logic [7:0] frame;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   // reference model state
   int m_mode = 0, m_bar = 0, m_frame = 0;
   bit m_prev_vs = 1'b1, m_prev_ok = 1'b0;

   function automatic logic [7:0] ref_rgb(input int md, input int px, input int py, input int bar);
      logic [7:0] bars [8];
      bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
      case (md)
         0:       return bars[px / 80];
         1:       return (((px / 32) + (py / 32)) % 2 == 1) ? 8'hFF : 8'h00;
         2:       return (px % 32 == 0 || py % 32 == 0 || px == 639 || py == 479) ? 8'hFF : 8'h03;
         default: return (px >= bar && px < bar + 32) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
   endtask

   // Drive one sample at the falling edge and push the output it must produce 2 clocks later.
   task automatic step(input bit rst, input bit hs, input bit vs, input bit bl,
                       input int px, input int py, input int md);
      exp_t e;
      @(negedge CLK);
      RST = rst; HS = hs; VS = vs; blank = bl;
      x = 10'(px); y = 10'(py); MODE = 2'(md);
      if (rst) begin
         // the sample still in flight is wiped by this reset edge
         if (q.size() > 0 && q[q.size()-1].due == cyc + 1)
            q[q.size()-1] = '{cyc + 1, 1'b1, 1'b1, 8'h00, 8'h00};
         m_mode = 0; m_bar = 0; m_frame = 0; m_prev_ok = 1'b0; m_prev_vs = 1'b1;
         e = '{cyc + 2, 1'b1, 1'b1, 8'h00, 8'h00};
      end else begin
         logic [7:0] c;
         c = bl ? 8'h00 : ref_rgb(m_mode, px, py, m_bar);
         if (m_prev_ok && m_prev_vs && !vs) begin
            m_mode  = md;
            m_bar   = (m_bar + 4 > 636) ? 0 : m_bar + 4;
            m_frame = (m_frame + 1) % 256;
         end
         m_prev_vs = vs;
         m_prev_ok = 1'b1;
         e = '{cyc + 2, hs, vs, c, 8'(m_frame)};
      end
      q.push_back(e);
   endtask

   task automatic pix(input int px, input int py, input bit bl);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1, bl, px, py, int'($urandom_range(0, 3)));
   endtask

   task automatic rpix();
      pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0);
   endtask

   task automatic fs(input int md);
      rpix();
      step(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), md);
      rpix();
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
               n_chk++;
               $display("FAIL late_entry: due %0d seen at cycle %0d", e.due, cyc);
            end else begin
               chk("rgb",   RGB,          e.rgb);
               chk("hs_o",  {7'd0, HS_O}, {7'd0, e.hs});
               chk("vs_o",  {7'd0, VS_O}, {7'd0, e.vs});
               chk("frame", FRAME,        e.frame);
            end
         end
      end
   end

   initial begin
      RST = 1'b1; HS = 1'b1; VS = 1'b1; blank = 1'b1; x = '0; y = '0; MODE = '0;

      // reset with VS low at release: must not count as a frame start
      step(1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 5, 5, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 100, 100, 2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 200, 100, 3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b0, 10 * i, 7, 1);

      // colour bar edges
      fs(0);
      for (int px = 78; px <= 81; px++) pix(px, 100, 1'b0);
      pix(639, 100, 1'b0);
      for (int i = 0; i < 8; i++) pix(i * 80 + int'($urandom_range(0, 79)), 50, 1'b0);

      // mid-frame MODE change is ignored until the next frame start
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 200, 40, 1);
      fs(1);
      pix(32, 0, 1'b0);
      pix(32, 32, 1'b0);
      for (int i = 0; i < 6; i++) rpix();

      // blank forces black in every mode
      for (int m = 0; m < 4; m++) begin
         fs(m);
         for (int i = 0; i < 4; i++) pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
         pix(0, 0, 1'b1);
      end

      // VS fall coinciding with reset
      step(1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 2);
      for (int i = 0; i < 3; i++) rpix();

      // moving bar: 160 frame starts from reset
      step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
      for (int i = 1; i <= 160; i++) begin
         fs(3);
         if (i == 159) begin
            pix(639, 10, 1'b0);
            pix(635, 10, 1'b0);
            pix(636, 10, 1'b0);
         end
         if (i == 160) begin
            pix(0, 10, 1'b0);
            pix(31, 10, 1'b0);
            pix(32, 10, 1'b0);
         end
      end

      // grid mode through the FRAME wrap
      for (int i = 161; i <= 300; i++) begin
         fs(2);
         if (i % 20 == 0 || i == 256 || i == 257) begin
            pix(0, 7, 1'b0);
            pix(7, 7, 1'b0);
            pix(639, 200, 1'b0);
            pix(100, 479, 1'b0);
         end
      end

      // fully random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
              int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
      #2;
      if (q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
